// File: rtl/cpu_idecode_if.sv
// ============================================================================
// Module      : cpu_idecode_if
// Description : Fetch, writeback and D-stage bundle for the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_idecode_if;
    // fetch side
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        stall;
    logic        flush;
    // writeback side
    logic        w_en;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    // D-stage register
    logic        d_valid;
    logic [31:0] d_pc;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  d_rd;
    logic [31:0] d_rs1_val;
    logic [31:0] d_rs2_val;
    logic [31:0] d_imm;
    logic [3:0]  d_alu_op;
    logic        d_reg_we;
    logic        d_mem_rd;
    logic        d_mem_wr;
    logic        d_branch;
    logic        d_jump;
    logic        d_illegal;

    modport slave (
        input  f_instr, f_pc, stall, flush, w_en, w_rd, w_data,
        output d_valid, d_pc, d_rs1, d_rs2, d_rd, d_rs1_val, d_rs2_val,
               d_imm, d_alu_op, d_reg_we, d_mem_rd, d_mem_wr, d_branch,
               d_jump, d_illegal
    );

    modport master (
        output f_instr, f_pc, stall, flush, w_en, w_rd, w_data,
        input  d_valid, d_pc, d_rs1, d_rs2, d_rd, d_rs1_val, d_rs2_val,
               d_imm, d_alu_op, d_reg_we, d_mem_rd, d_mem_wr, d_branch,
               d_jump, d_illegal
    );
endinterface

`default_nettype wire

// File: rtl/cpu_idecode.sv
// ============================================================================
// Module      : cpu_idecode
// Description : RV32I decode stage: register file with write bypass, immediate
//               and control generation, D-stage pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_idecode #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    cpu_idecode_if.slave  bus
);

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_MISC   = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    logic [31:0] r_rf [0:31];

    logic [31:0] w_instr;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_wr_ok;

    logic [31:0] w_imm;
    logic        w_alt;
    logic        w_reg_we;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_branch;
    logic        w_jump;
    logic        w_illegal;

    assign w_instr = bus.f_instr;
    assign w_opc   = w_instr[6:0];
    assign w_f3    = w_instr[14:12];
    assign w_f7    = w_instr[31:25];
    assign w_rs1   = w_instr[19:15];
    assign w_rs2   = w_instr[24:20];
    assign w_rd    = w_instr[11:7];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'h000};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};

    // A writeback landing this cycle is visible to the capture through the bypass.
    assign w_wr_ok   = bus.w_en && (bus.w_rd != 5'd0);
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'h0 :
                       (w_wr_ok && bus.w_rd == w_rs1) ? bus.w_data : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'h0 :
                       (w_wr_ok && bus.w_rd == w_rs2) ? bus.w_data : r_rf[w_rs2];

    always_comb begin
        w_imm     = 32'h0;
        w_alt     = 1'b0;
        w_reg_we  = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_branch  = 1'b0;
        w_jump    = 1'b0;
        w_illegal = 1'b0;
        case (w_opc)
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_imm    = w_imm_u;
                w_reg_we = 1'b1;
            end
            c_OPC_JAL: begin
                w_imm    = w_imm_j;
                w_reg_we = 1'b1;
                w_jump   = 1'b1;
            end
            c_OPC_JALR: begin
                w_imm     = w_imm_i;
                w_reg_we  = 1'b1;
                w_jump    = 1'b1;
                w_illegal = (w_f3 != 3'b000);
            end
            c_OPC_BRANCH: begin
                w_imm     = w_imm_b;
                w_branch  = 1'b1;
                w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OPC_LOAD: begin
                w_imm     = w_imm_i;
                w_reg_we  = 1'b1;
                w_mem_rd  = 1'b1;
                w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            c_OPC_STORE: begin
                w_imm     = w_imm_s;
                w_mem_wr  = 1'b1;
                w_illegal = (w_f3 > 3'b010);
            end
            c_OPC_OPIMM: begin
                w_imm    = w_imm_i;
                w_reg_we = 1'b1;
                if (w_f3 == 3'b001) begin
                    w_illegal = (w_f7 != 7'h00);
                end else if (w_f3 == 3'b101) begin
                    w_alt     = w_instr[30];
                    w_illegal = (w_f7 != 7'h00) && (w_f7 != 7'h20);
                end
            end
            c_OPC_OP: begin
                w_reg_we = 1'b1;
                w_alt    = w_instr[30];
                if (w_f7 == 7'h20) begin
                    w_illegal = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                end else begin
                    w_illegal = (w_f7 != 7'h00);
                end
            end
            c_OPC_MISC, c_OPC_SYSTEM: begin
                w_illegal = 1'b0;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // Illegal encodings carry no side effects; the trap logic in execute decides.
        if (w_illegal) begin
            w_reg_we = 1'b0;
            w_mem_rd = 1'b0;
            w_mem_wr = 1'b0;
            w_branch = 1'b0;
            w_jump   = 1'b0;
        end
        if (w_rd == 5'd0) begin
            w_reg_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0;
            end
        end else if (w_wr_ok) begin
            r_rf[bus.w_rd] <= bus.w_data;
        end
    end

    logic        r_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_rs1_val;
    logic [31:0] r_rs2_val;
    logic [31:0] r_imm;
    logic [3:0]  r_alu_op;
    logic        r_reg_we;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_branch;
    logic        r_jump;
    logic        r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_VECTOR;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_rd      <= 5'd0;
            r_rs1_val <= 32'h0;
            r_rs2_val <= 32'h0;
            r_imm     <= 32'h0;
            r_alu_op  <= 4'h0;
            r_reg_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (bus.flush) begin
            r_valid   <= 1'b0;
            r_reg_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!bus.stall) begin
            r_valid   <= 1'b1;
            r_pc      <= bus.f_pc;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_rs1_val <= w_rs1_val;
            r_rs2_val <= w_rs2_val;
            r_imm     <= w_imm;
            r_alu_op  <= {w_alt, w_f3};
            r_reg_we  <= w_reg_we;
            r_mem_rd  <= w_mem_rd;
            r_mem_wr  <= w_mem_wr;
            r_branch  <= w_branch;
            r_jump    <= w_jump;
            r_illegal <= w_illegal;
        end
    end

    assign bus.d_valid   = r_valid;
    assign bus.d_pc      = r_pc;
    assign bus.d_rs1     = r_rs1;
    assign bus.d_rs2     = r_rs2;
    assign bus.d_rd      = r_rd;
    assign bus.d_rs1_val = r_rs1_val;
    assign bus.d_rs2_val = r_rs2_val;
    assign bus.d_imm     = r_imm;
    assign bus.d_alu_op  = r_alu_op;
    assign bus.d_reg_we  = r_reg_we;
    assign bus.d_mem_rd  = r_mem_rd;
    assign bus.d_mem_wr  = r_mem_wr;
    assign bus.d_branch  = r_branch;
    assign bus.d_jump    = r_jump;
    assign bus.d_illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_cpu_idecode.sv
// ============================================================================
// Module      : tb_cpu_idecode
// Description : Directed self-checking bench for the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_idecode;

    localparam logic [31:0] c_RESET_VECTOR = 32'h0000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cpu_idecode_if bus ();

    cpu_idecode #(
        .RESET_VECTOR (c_RESET_VECTOR)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the edge that loaded them.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] instr, input logic [31:0] pc);
        bus.f_instr = instr;
        bus.f_pc    = pc;
        step();
    endtask

    // {reg_we, mem_rd, mem_wr, branch, jump, illegal}
    function automatic logic [31:0] ctl();
        return {26'd0, bus.d_reg_we, bus.d_mem_rd, bus.d_mem_wr,
                bus.d_branch, bus.d_jump, bus.d_illegal};
    endfunction

    function automatic logic [31:0] add_rr(input logic [4:0] rs);
        return {7'b0, rs, rs, 3'b000, 5'd0, 7'h33};
    endfunction

    logic [31:0] ill_vec [4];

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus.f_instr = 32'h13;
        bus.f_pc    = 32'h0;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        bus.w_en    = 1'b0;
        bus.w_rd    = 5'd0;
        bus.w_data  = 32'h0;

        // reset with random instructions; second cycle also has stall+flush raised
        cap($urandom, $urandom);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        cap($urandom, $urandom);
        chk("rst_valid", {31'd0, bus.d_valid}, 32'd0);
        chk("rst_pc", bus.d_pc, c_RESET_VECTOR);
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_imm", bus.d_imm, 32'd0);
        chk("rst_aluop", {28'd0, bus.d_alu_op}, 32'd0);
        chk("rst_rs1val", bus.d_rs1_val, 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        rst = 1'b0;
        cap(32'h13, 32'h0);
        chk("nop_valid", {31'd0, bus.d_valid}, 32'd1);
        chk("nop_ctl", ctl(), 32'd0);

        for (int i = 1; i < 32; i++) begin
            cap(add_rr(5'(i)), 32'h0);
            chk($sformatf("rst_x%0d", i), bus.d_rs1_val, 32'd0);
        end

        // addi x1,x0,-1 while writing x2 = 0x40
        bus.w_en = 1'b1; bus.w_rd = 5'd2; bus.w_data = 32'h40;
        cap(32'hFFF00093, 32'h100);
        bus.w_en = 1'b0;
        chk("addi_imm", bus.d_imm, 32'hFFFF_FFFF);
        chk("addi_rd", {27'd0, bus.d_rd}, 32'd1);
        chk("addi_ctl", ctl(), 32'b100000);
        chk("addi_aluop", {28'd0, bus.d_alu_op}, 32'h0);
        chk("addi_pc", bus.d_pc, 32'h100);

        // srai x3,x2,5
        cap(32'h40515193, 32'h104);
        chk("srai_aluop", {28'd0, bus.d_alu_op}, 32'hD);
        chk("srai_imm", bus.d_imm, 32'h405);
        chk("srai_rs1val", bus.d_rs1_val, 32'h40);
        chk("srai_rd", {27'd0, bus.d_rd}, 32'd3);

        // bypass: write x5 in the capture cycle of add x6,x5,x5
        bus.w_en = 1'b1; bus.w_rd = 5'd5; bus.w_data = 32'hDEADBEEF;
        cap(32'h00528333, 32'h108);
        bus.w_en = 1'b0;
        chk("byp_rs1", bus.d_rs1_val, 32'hDEADBEEF);
        chk("byp_rs2", bus.d_rs2_val, 32'hDEADBEEF);
        chk("add_imm", bus.d_imm, 32'd0);
        chk("add_ctl", ctl(), 32'b100000);
        cap(32'h00528333, 32'h10C);
        chk("arr_rs1", bus.d_rs1_val, 32'hDEADBEEF);

        bus.w_en = 1'b1; bus.w_rd = 5'd0; bus.w_data = 32'hFFFF_FFFF;
        cap(32'h00000033, 32'h110);
        bus.w_en = 1'b0;
        chk("x0_byp", bus.d_rs1_val, 32'd0);
        cap(32'h00000033, 32'h114);
        chk("x0_arr", bus.d_rs2_val, 32'd0);

        // sw x1,4(x2)
        cap(32'h00112223, 32'h118);
        chk("sw_ctl", ctl(), 32'b001000);
        chk("sw_imm", bus.d_imm, 32'd4);
        chk("sw_rs1val", bus.d_rs1_val, 32'h40);
        bus.stall = 1'b1; bus.flush = 1'b1;
        cap(32'h00112223, 32'h11C);
        bus.stall = 1'b0; bus.flush = 1'b0;
        chk("flush_valid", {31'd0, bus.d_valid}, 32'd0);
        chk("flush_ctl", ctl(), 32'd0);

        // lw x4,8(x2) then a 3-cycle stall with a writeback to x2
        cap(32'h00812203, 32'h120);
        chk("lw_ctl", ctl(), 32'b110000);
        chk("lw_imm", bus.d_imm, 32'd8);
        bus.stall = 1'b1;
        bus.w_en = 1'b1; bus.w_rd = 5'd2; bus.w_data = 32'h9999;
        for (int k = 0; k < 3; k++) begin
            cap($urandom, $urandom);
            bus.w_en = 1'b0;
            chk("stall_pc", bus.d_pc, 32'h120);
            chk("stall_imm", bus.d_imm, 32'd8);
            chk("stall_rs1val", bus.d_rs1_val, 32'h40);
            chk("stall_ctl", ctl(), 32'b110000);
        end
        bus.stall = 1'b0;

        // jal x1,8
        cap(32'h008000EF, 32'h124);
        chk("jal_pc", bus.d_pc, 32'h124);
        chk("jal_ctl", ctl(), 32'b100010);
        chk("jal_imm", bus.d_imm, 32'd8);

        // beq x1,x2,-4 (x2 now 0x9999 from the stalled writeback)
        cap(32'hFE208EE3, 32'h128);
        chk("beq_ctl", ctl(), 32'b000100);
        chk("beq_imm", bus.d_imm, 32'hFFFF_FFFC);
        chk("beq_rs2val", bus.d_rs2_val, 32'h9999);

        // lui x5,0x12345
        cap(32'h123452B7, 32'h12C);
        chk("lui_imm", bus.d_imm, 32'h1234_5000);
        chk("lui_ctl", ctl(), 32'b100000);

        // lw x0,0(x1): legal load, no register write
        cap(32'h0000A003, 32'h130);
        chk("lwx0_ctl", ctl(), 32'b010000);

        // illegal: low bits 00, BRANCH f3=010, OP with M funct7, srai-like funct7=0x10
        ill_vec[0] = 32'h00000000;
        ill_vec[1] = 32'h0000A063;
        ill_vec[2] = 32'h02000033;
        ill_vec[3] = 32'h20515193;
        for (int k = 0; k < 4; k++) begin
            cap(ill_vec[k], 32'h200 + 32'(k * 4));
            chk($sformatf("ill%0d_ctl", k), ctl(), 32'b000001);
            chk($sformatf("ill%0d_valid", k), {31'd0, bus.d_valid}, 32'd1);
        end

        // second reset must clear previously written registers
        bus.w_en = 1'b1; bus.w_rd = 5'd7; bus.w_data = 32'h1234;
        cap(32'h13, 32'h300);
        bus.w_en = 1'b0;
        cap(add_rr(5'd7), 32'h304);
        chk("x7_written", bus.d_rs1_val, 32'h1234);
        rst = 1'b1;
        bus.stall = 1'b1;
        cap(32'h13, 32'h308);
        chk("rst2_valid", {31'd0, bus.d_valid}, 32'd0);
        chk("rst2_pc", bus.d_pc, c_RESET_VECTOR);
        rst = 1'b0;
        bus.stall = 1'b0;
        cap(add_rr(5'd7), 32'h30C);
        chk("rst2_x7", bus.d_rs1_val, 32'd0);
        chk("rst2_nxt_valid", {31'd0, bus.d_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
